// File: rtl/uart_rx_bit_timer.sv
// Oversampling bit/frame timer for the UART receive path: edge and bit counters plus sample,
// bit-boundary and end-of-frame decodes. Define UART_RX_SAMPLE3_EN for triple-sample (majority) strobes.
module uart_rx_bit_timer #(
    parameter int PRESC_W    = 6,
    parameter int BITCNT_W   = 4,
    parameter int START_SKIP = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                enable,
    input  logic [PRESC_W-1:0]  Prescale,
    input  logic [BITCNT_W-1:0] frame_bits,
    output logic [PRESC_W-1:0]  edge_cnt,
    output logic [BITCNT_W-1:0] bit_cnt,
    output logic                sample_stb,
    output logic [1:0]          sample_idx,
    output logic                bit_done,
    output logic                frame_done,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [PRESC_W-1:0]  PRESC_MIN = PRESC_W'(8);
    localparam logic [BITCNT_W-1:0] NBITS_MIN = BITCNT_W'(2);
    localparam logic [PRESC_W-1:0]  SKIP_LD   = PRESC_W'(START_SKIP);

    state_t              state, state_next;
    logic [PRESC_W-1:0]  presc_q;
    logic [BITCNT_W-1:0] nbits_q;
    logic [PRESC_W-1:0]  presc_clamped;
    logic [BITCNT_W-1:0] nbits_clamped;
    logic [PRESC_W-1:0]  mid;
    logic                last_edge;
    logic                last_bit;

    // Clamping keeps presc_q-1 and nbits_q-1 from underflowing.
    assign presc_clamped = (Prescale < PRESC_MIN) ? PRESC_MIN : Prescale;
    assign nbits_clamped = (frame_bits < NBITS_MIN) ? NBITS_MIN : frame_bits;

    assign mid       = presc_q >> 1;
    assign last_edge = (edge_cnt == presc_q - 1'b1);
    assign last_bit  = (bit_cnt == nbits_q - 1'b1);
    assign state_dbg = state;

    // State register, counters and per-frame latches.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            presc_q  <= PRESC_MIN;
            nbits_q  <= NBITS_MIN;
        end else begin
            state <= state_next;
            if (!enable) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        edge_cnt <= SKIP_LD;
                        bit_cnt  <= '0;
                        presc_q  <= presc_clamped;
                        nbits_q  <= nbits_clamped;
                    end
                    COUNT: begin
                        if (last_edge) begin
                            edge_cnt <= '0;
                            bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                    default: begin
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Dropping enable wins over every other transition, including the frame wrap.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = COUNT;
                COUNT:   state_next = (last_edge && last_bit) ? HOLD : COUNT;
                HOLD:    state_next = HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Decodes are taken straight from registered state so they line up with the counters.
    always_comb begin
        busy       = (state == COUNT);
        bit_done   = busy && last_edge;
        frame_done = bit_done && last_bit;
        sample_stb = 1'b0;
        sample_idx = 2'd0;
`ifdef UART_RX_SAMPLE3_EN
        if (busy) begin
            if (edge_cnt == mid - 1'b1) begin
                sample_stb = 1'b1;
                sample_idx = 2'd0;
            end else if (edge_cnt == mid) begin
                sample_stb = 1'b1;
                sample_idx = 2'd1;
            end else if (edge_cnt == mid + 1'b1) begin
                sample_stb = 1'b1;
                sample_idx = 2'd2;
            end
        end
`else
        if (busy && edge_cnt == mid) begin
            sample_stb = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: directed frames from the test plan plus randomized
// enable/prescale/reset activity, compared cycle by cycle against a queue-based frame model.
module tb_uart_rx_bit_timer;
  localparam int PRESC_W    = 6;
  localparam int BITCNT_W   = 4;
  localparam int START_SKIP = 3;
  localparam int W          = PRESC_W + BITCNT_W;

  logic                clk;
  logic                rst;
  logic                enable;
  logic [PRESC_W-1:0]  prescale;
  logic [BITCNT_W-1:0] frame_bits;
  logic [PRESC_W-1:0]  edge_cnt;
  logic [BITCNT_W-1:0] bit_cnt;
  logic                sample_stb;
  logic [1:0]          sample_idx;
  logic                bit_done;
  logic                frame_done;
  logic                busy;
  logic [1:0]          state_dbg;

  uart_rx_bit_timer #(
    .PRESC_W(PRESC_W),
    .BITCNT_W(BITCNT_W),
    .START_SKIP(START_SKIP)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .enable(enable),
    .Prescale(prescale),
    .frame_bits(frame_bits),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .sample_stb(sample_stb),
    .sample_idx(sample_idx),
    .bit_done(bit_done),
    .frame_done(frame_done),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;
  int fd_count;

  // model: 0 = idle, 1 = counting, 2 = holding; exp_q holds the remaining {edge,bit} of the frame
  int                 m_mode;
  int                 m_p;
  int                 m_n;
  logic [W-1:0]       exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      m_mode = 0;
      exp_q.delete();
    end else if (!enable) begin
      m_mode = 0;
      exp_q.delete();
    end else if (m_mode == 0) begin
      m_p = (int'(prescale) < 8) ? 8 : int'(prescale);
      m_n = (int'(frame_bits) < 2) ? 2 : int'(frame_bits);
      exp_q.delete();
      for (int b = 0; b < m_n; b++)
        for (int e = (b == 0) ? START_SKIP : 0; e < m_p; e++)
          exp_q.push_back({PRESC_W'(e), BITCNT_W'(b)});
      m_mode = 1;
    end else if (m_mode == 1) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_mode = 2;
    end
  endtask

  task automatic compare();
    int e, b, mid;
    logic x_stb;
    int x_idx;
    logic x_bd, x_fd;
    e = 0; b = 0; x_stb = 1'b0; x_idx = 0; x_bd = 1'b0; x_fd = 1'b0;
    if (m_mode == 1) begin
      e   = int'(exp_q[0][W-1:BITCNT_W]);
      b   = int'(exp_q[0][BITCNT_W-1:0]);
      mid = m_p / 2;
      x_bd = (e == m_p - 1);
      x_fd = x_bd && (b == m_n - 1);
`ifdef UART_RX_SAMPLE3_EN
      if (e >= mid - 1 && e <= mid + 1) begin
        x_stb = 1'b1;
        x_idx = e - (mid - 1);
      end
`else
      x_stb = (e == mid);
`endif
    end
    check("edge_cnt", 32'(edge_cnt), 32'(e));
    check("bit_cnt", 32'(bit_cnt), 32'(b));
    check("busy", 32'(busy), 32'(m_mode == 1));
    check("bit_done", 32'(bit_done), 32'(x_bd));
    check("frame_done", 32'(frame_done), 32'(x_fd));
    check("sample_stb", 32'(sample_stb), 32'(x_stb));
    check("sample_idx", 32'(sample_idx), 32'(x_idx));
  endtask

  // driver: one clock, update model, then sample away from the edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (busy) busy_cycles++;
    if (frame_done) fd_count++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic start_frame(input int p, input int n);
    prescale    = PRESC_W'(p);
    frame_bits  = BITCNT_W'(n);
    enable      = 1'b1;
    busy_cycles = 0;
    fd_count    = 0;
  endtask

  task automatic idle_cycle();
    enable = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; prescale = '0; frame_bits = '0;
    m_mode = 0; m_p = 8; m_n = 2;
    run(2);
    rst = 1'b1;
    cycle();

    // plan 1: 8x oversampling, 10-bit frame
    start_frame(8, 10);
    cycle();
    check("p1_first_edge", 32'(edge_cnt), 32'd3);
    run(89);
    check("p1_busy_cycles", 32'(busy_cycles), 32'd77);
    check("p1_frame_done_count", 32'(fd_count), 32'd1);
    check("p1_hold_busy", 32'(busy), 32'd0);
    idle_cycle();

    // plan 2: 16x oversampling, sample strobes around mid-bit
    start_frame(16, 3);
    run(50);
    idle_cycle();

    // plan 3: clamped to 8 and 2
    start_frame(4, 1);
    run(20);
    check("p3_busy_cycles", 32'(busy_cycles), 32'd13);
    check("p3_frame_done_count", 32'(fd_count), 32'd1);
    idle_cycle();

    // plan 4: prescale change mid-frame only affects the next frame
    start_frame(8, 6);
    run(29);
    check("p4_bit_at_change", 32'(bit_cnt), 32'd3);
    prescale = PRESC_W'(32);
    run(30);
    check("p4_busy_cycles_8x", 32'(busy_cycles), 32'd45);
    idle_cycle();
    start_frame(32, 6);
    run(200);
    check("p4_busy_cycles_32x", 32'(busy_cycles), 32'd189);
    check("p4_frame_done_count", 32'(fd_count), 32'd1);
    idle_cycle();

    // plan 5: enable dropped mid-frame
    start_frame(8, 10);
    run(32);
    check("p5_bit", 32'(bit_cnt), 32'd4);
    check("p5_edge", 32'(edge_cnt), 32'd2);
    idle_cycle();
    check("p5_no_frame_done", 32'(fd_count), 32'd0);
    enable = 1'b1;
    cycle();
    check("p5_reload_edge", 32'(edge_cnt), 32'd3);
    idle_cycle();

    // plan 6: reset on the final edge of a frame
    start_frame(8, 2);
    run(13);
    check("p6_frame_done_before_reset", 32'(frame_done), 32'd1);
    rst = 1'b0;
    cycle();
    check("p6_reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    run(2);
    check("p6_restart_not_hold", 32'(busy), 32'd1);
    idle_cycle();

    // randomized activity
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 49) == 0) prescale = PRESC_W'($urandom_range(0, 40));
      if ($urandom_range(0, 49) == 0) frame_bits = BITCNT_W'($urandom_range(0, 12));
      if (!enable) enable = ($urandom_range(0, 3) != 0);
      else if ($urandom_range(0, 299) == 0) enable = 1'b0;
      rst = ($urandom_range(0, 799) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
Parametrised oversampling timer for the UART receive path. It counts prescaled clock edges within each bit and bits within each frame, and decodes mid-bit sample strobes, bit-boundary and end-of-frame pulses for the RX FSM and data sampler. Prescale and frame length are latched per frame, and a terminal HOLD state prevents counter wrap.

Parameters:
PRESC_W, 6, width of Prescale and edge_cnt
BITCNT_W, 4, width of frame_bits and bit_cnt
START_SKIP, 3, edge_cnt load value on frame start; compensates start-edge detection latency; must be <= (8>>1)-1

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-low reset
enable  input  1  frame-active request from RX FSM
Prescale  input  PRESC_W  oversampling ratio (edges per bit)
frame_bits  input  BITCNT_W  total bits per frame incl. start/parity/stop
edge_cnt  output  PRESC_W  edge position within current bit
bit_cnt  output  BITCNT_W  bit index within frame
sample_stb  output  1  sample point strobe
sample_idx  output  2  index of current sample (0..2)
bit_done  output  1  last edge of current bit
frame_done  output  1  last edge of last bit
busy  output  1  state is COUNT

Behaviour:
- One clock (CLK); RST synchronous, active-low: clears every register on the CLK edge while RST=0.
- Reset values: state=IDLE, edge_cnt=0, bit_cnt=0, presc_q=8, nbits_q=2. All strobes and busy are 0 (decoded only in COUNT).
- States: IDLE, COUNT, HOLD.
- Latching: on the IDLE->COUNT transition, presc_q = max(Prescale, 8) and nbits_q = max(frame_bits, 2). Changes to Prescale or frame_bits during a frame have no effect until the next frame.
- IDLE: counters held at 0. When enable=1: next state COUNT, edge_cnt<=START_SKIP, bit_cnt<=0.
- COUNT:
  - If edge_cnt==presc_q-1: edge_cnt<=0, bit_cnt<=bit_cnt+1.
  - If additionally bit_cnt==nbits_q-1: state<=HOLD and both counters <=0.
  - Otherwise: edge_cnt<=edge_cnt+1.
- HOLD: counters held at 0. Waits for enable=0, then goes to IDLE. No restart occurs without enable going low.
- enable=0 in any state: next cycle state=IDLE, counters=0. This takes priority over every other transition, including the wrap cycle.
- Decodes are combinational from registered state, so they have zero latency relative to the counters:
  - mid = presc_q>>1.
  - bit_done = (state==COUNT) && edge_cnt==presc_q-1.
  - frame_done = bit_done && bit_cnt==nbits_q-1.
  - busy = (state==COUNT).
- Widths: all compares use PRESC_W/BITCNT_W-bit unsigned arithmetic. presc_q-1 never underflows because of the clamp. bit_cnt cannot wrap because the frame terminates at nbits_q-1.
- RST=0 mid-frame: the next cycle is the reset state, and no frame_done is emitted.

Optional Feature:
Macro: UART_RX_SAMPLE3_EN.
- Defined: triple-sample (majority) mode. sample_stb=1 in COUNT when edge_cnt is mid-1, mid or mid+1, with sample_idx=0, 1, 2 respectively.
- Not defined: single-sample mode. sample_stb=1 in COUNT only when edge_cnt==mid, and sample_idx is tied to 0.

Test Plan:
1. Prescale=8, frame_bits=10, enable held high:
   - edge_cnt sequence 3,4,5,6,7,0,1… in the first bit.
   - bit_done on every edge_cnt=7.
   - frame_done exactly once, at bit_cnt=9, edge_cnt=7 (first bit lasts 5 cycles, later bits 8 cycles, 77 cycles in COUNT).
   - Then HOLD with busy=0.
2. Prescale=16, UART_RX_SAMPLE3_EN defined: sample_stb on edge_cnt 7,8,9 with sample_idx 0,1,2. Macro undefined: single strobe at edge_cnt 8 with sample_idx=0.
3. Prescale=4, frame_bits=1: clamped to 8 and 2; frame_done after 5+8 cycles.
4. Prescale changed 8->32 at bit_cnt=3: timing stays at 8 until frame end; the next frame (after an enable low/high cycle) uses 32.
5. enable dropped at bit_cnt=4, edge_cnt=2: next cycle IDLE, counters 0, no frame_done. Re-assertion reloads edge_cnt=3.
6. RST=0 asserted in COUNT at edge_cnt=presc_q-1: next cycle all reset values, and bit_done/frame_done are not followed by any HOLD entry.
